// File: rtl/counter_down.sv
// Loadable down-counter with a three-state IDLE/RUN/DONE controller and an
// optional automatic reload from the value captured at start.
module counter_down #(
    parameter int N      = 3,
    parameter bit RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] value,
    input  logic         en,
    input  logic         abort,
    output logic [N-1:0] counter,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] counter_nxt;
    logic [N-1:0] reload_q;
    logic [N-1:0] reload_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            counter  <= '0;
            reload_q <= '0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            reload_q <= reload_nxt;
        end
    end

    // NOTE: every combinational output gets a hold default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        reload_nxt  = reload_q;
        case (state)
            IDLE: begin
                if (start) begin
                    counter_nxt = value;
                    reload_nxt  = value;
                    state_nxt   = (value != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    counter_nxt = '0;
                    state_nxt   = IDLE;
                end else if (en) begin
                    // Terminal step lands exactly on zero; the count never wraps.
                    if (counter > N'(1)) begin
                        counter_nxt = counter - N'(1);
                    end else begin
                        counter_nxt = '0;
                        state_nxt   = DONE;
                    end
                end
            end
            DONE: begin
                if (RELOAD && (reload_q != '0)) begin
                    counter_nxt = reload_q;
                    state_nxt   = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                counter_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_counter_down.sv
// Self-checking bench for counter_down: one RELOAD=0 and one RELOAD=1
// instance share stimulus and are compared every cycle against a flag-based model.
module tb_counter_down;

    logic       clk;
    logic       clr;
    logic       start;
    logic [2:0] value;
    logic       en;
    logic       abort;
    logic [2:0] counter0, counter1;
    logic       busy0, busy1, done0, done1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining count plus busy/done flags per instance
    // (index 0: no reload, index 1: reload enabled).
    int m_cnt  [2];
    int m_rel  [2];
    bit m_busy [2];
    bit m_done [2];

    counter_down #(.N(3), .RELOAD(1'b0)) dut0 (
        .clk(clk), .clr(clr), .start(start), .value(value), .en(en),
        .abort(abort), .counter(counter0), .busy(busy0), .done(done0)
    );

    counter_down #(.N(3), .RELOAD(1'b1)) dut1 (
        .clk(clk), .clr(clr), .start(start), .value(value), .en(en),
        .abort(abort), .counter(counter1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_rel[i]  = 0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit s, input int v, input bit e, input bit a);
        for (int i = 0; i < 2; i++) begin
            if (m_done[i]) begin
                m_done[i] = 1'b0;
                if (i == 1 && m_rel[i] != 0) begin
                    m_cnt[i]  = m_rel[i];
                    m_busy[i] = 1'b1;
                end
            end else if (m_busy[i]) begin
                if (a) begin
                    m_cnt[i]  = 0;
                    m_busy[i] = 1'b0;
                end else if (e) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else if (s) begin
                m_cnt[i] = v;
                m_rel[i] = v;
                if (v == 0) m_done[i] = 1'b1;
                else        m_busy[i] = 1'b1;
            end
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, compare on the falling edge.
    task automatic cycle(input string name, input bit s, input logic [2:0] v,
                         input bit e, input bit a);
        logic [4:0] act, exp;
        start = s;
        value = v;
        en    = e;
        abort = a;
        @(posedge clk);
        model_step(s, int'(v), e, a);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            act = (i == 0) ? {counter0, busy0, done0} : {counter1, busy1, done1};
            exp = {m_cnt[i][2:0], m_busy[i], m_done[i]};
            n_checks++;
            if (act !== exp)
                $display("FAIL %s dut%0d: counter=%0d busy=%0b done=%0b, expected counter=%0d busy=%0b done=%0b",
                         name, i, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
            else
                n_pass++;
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        value = 3'd0;
        en    = 1'b0;
        abort = 1'b0;
    endtask

    // Pull clr low between edges and confirm the outputs clear without a clock.
    task automatic reset_between_edges(input string name);
        #2 clr = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({counter0, busy0, done0, counter1, busy1, done1} !== 10'd0)
            $display("FAIL %s: counter0=%0d busy0=%0b done0=%0b counter1=%0d busy1=%0b done1=%0b, expected all zero",
                     name, counter0, busy0, done0, counter1, busy1, done1);
        else
            n_pass++;
        #1 clr = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({counter0, busy0, done0, counter1, busy1, done1} !== 10'd0)
            $display("FAIL reset_state: counter0=%0d busy0=%0b done0=%0b, expected all zero",
                     counter0, busy0, done0);
        else
            n_pass++;
        @(negedge clk);
        clr = 1'b1;
        cycle("start_after_reset", 1'b1, 3'd5, 1'b1, 1'b0);
        cycle("run_to_4", 1'b0, 3'd0, 1'b1, 1'b0);
        reset_between_edges("async_reset_mid_run");
        cycle("start_first_edge", 1'b1, 3'd3, 1'b1, 1'b0);
        idle_inputs();
        @(negedge clk);
        reset_between_edges("reset_clear");
        cycle("zero_load", 1'b1, 3'd0, 1'b0, 1'b0);
        reset_between_edges("async_reset_in_done");
        cycle("no_done_after_reset", 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_countdown();
        int done_edge = -1;
        cycle("count5_load", 1'b1, 3'd5, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cycle("count5", 1'b0, 3'd0, 1'b1, 1'b0);
            if (done0 && done_edge < 0) done_edge = k;
        end
        n_checks++;
        if (done_edge !== 5)
            $display("FAIL count5_done_edge: done at edge %0d, expected edge 5", done_edge);
        else
            n_pass++;
    endtask

    task automatic test_en_hold();
        int done_edge = -1;
        bit en_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cycle("hold_load", 1'b1, 3'd3, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle("hold", 1'b0, 3'd0, en_seq[k], 1'b0);
            if (done0 && done_edge < 0) done_edge = k + 1;
        end
        n_checks++;
        if (done_edge !== 5)
            $display("FAIL hold_done_edge: done at edge %0d, expected edge 5", done_edge);
        else
            n_pass++;
    endtask

    task automatic test_zero_value();
        cycle("zero_start", 1'b1, 3'd0, 1'b1, 1'b0);
        cycle("zero_after", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("zero_idle", 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        cycle("abort_load", 1'b1, 3'd6, 1'b1, 1'b0);
        cycle("abort_dec", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("abort_dec", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("start_in_run", 1'b1, 3'd2, 1'b0, 1'b0);
        cycle("abort_with_en", 1'b0, 3'd0, 1'b1, 1'b1);
        cycle("abort_no_done", 1'b0, 3'd0, 1'b1, 1'b0);
        cycle("abort_in_idle", 1'b0, 3'd0, 1'b1, 1'b1);
    endtask

    task automatic test_reload();
        int pulses = 0;
        cycle("reload_load", 1'b1, 3'd2, 1'b1, 1'b0);
        if (done1) pulses++;
        for (int k = 0; k < 8; k++) begin
            cycle("reload_run", 1'b0, 3'd0, 1'b1, 1'b0);
            if (done1) pulses++;
        end
        n_checks++;
        if (pulses !== 3)
            $display("FAIL reload_done_pulses: %0d pulses in 9 cycles, expected 3", pulses);
        else
            n_pass++;
        cycle("abort_in_done", 1'b0, 3'd0, 1'b1, 1'b1);
        cycle("reload_abort", 1'b0, 3'd0, 1'b1, 1'b1);
        cycle("reload_idle", 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_full_range();
        cycle("full_load", 1'b1, 3'd7, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++)
            cycle("full_range", 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 2)
                reset_between_edges("random_reset");
            else
                cycle("random", ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_en_hold();
        test_zero_value();
        test_abort();
        test_reload();
        test_full_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_down.md
COUNTER_DOWN -- requirements
Module: counter_down

Interface
REQ-001 Parameter: N, default 3, bit width of the counter and load value.
REQ-002 Parameter: RELOAD, default 0; 1 enables automatic reload from the captured value after each terminal count.
REQ-003 Port: clk  in  1  rising-edge clock, the block's only clock.
REQ-004 Port: clr  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  load-and-run request, sampled on rising clk.
REQ-006 Port: value  in  N  start value, sampled when start is accepted.
REQ-007 Port: en  in  1  count enable; one decrement per enabled cycle.
REQ-008 Port: abort  in  1  cancel an active count.
REQ-009 Port: counter  out  N  current count, registered.
REQ-010 Port: busy  out  1  high while in RUN, registered.
REQ-011 Port: done  out  1  one-cycle terminal-count pulse, registered.

Function
REQ-012 The block SHALL implement a 3-state FSM with states IDLE, RUN and DONE; busy=(state==RUN) and done=(state==DONE); both are Moore outputs.
REQ-013 In IDLE, counter SHALL hold; start=1 SHALL load counter<=value and capture value into an internal reload register.
REQ-014 Start in IDLE with value!=0 SHALL go to RUN; with value==0 it SHALL go directly to DONE.
REQ-015 In RUN, en=1 with counter>1 SHALL decrement by 1; en=1 with counter==1 SHALL set counter<=0 and go to DONE; en=0 SHALL hold counter and state.
REQ-016 In RUN, abort=1 SHALL force counter<=0 and state<=IDLE with no done pulse; abort has priority over en.
REQ-017 Start SHALL be ignored in RUN and DONE; abort SHALL be ignored in IDLE and DONE.
REQ-018 DONE SHALL last exactly one cycle. With RELOAD=0 the next state SHALL be IDLE, with counter held at 0.
REQ-019 DONE with RELOAD=1 and reload register !=0 SHALL load counter<=reload register and go to RUN; with reload register ==0 it SHALL go to IDLE.
REQ-020 Latency: start accepted at edge k, value=V>0, en held 1: counter=V after edge k, counter=0 and done=1 after edge k+V, busy=0 after edge k+V.
REQ-021 Counter arithmetic SHALL be unsigned N-bit and SHALL never underflow; the 0 -> 2^N-1 transition SHALL NOT occur.
REQ-022 value=2^N-1 SHALL be accepted and SHALL count through the full range.

Reset
REQ-023 clr=0 SHALL immediately, without a clock edge, force state=IDLE, counter=0, busy=0, done=0 and reload register=0.
REQ-024 Reset asserted in any state, including mid-RUN or during DONE, SHALL abandon the operation and produce no done pulse.
REQ-025 After clr rises, the first rising clk edge SHALL be able to accept start.

Verification
REQ-026 N=3, RUN at counter=4, pull clr low between edges -> counter=0, busy=0 and done=0 before the next edge; after release, start accepted on the first edge.
REQ-027 N=3, start with value=5, en=1 continuous -> counter 5,4,3,2,1,0 on successive edges; done=1 for exactly one cycle after the 5th edge following load; busy then 0.
REQ-028 value=3, en held low for 2 cycles after the first decrement -> counter holds at 2; done arrives 2 cycles later than the continuous-en case.
REQ-029 start with value=0 -> done=1 on the following cycle, busy never asserted, counter stays 0.
REQ-030 RUN at counter=4, abort=1 and en=1 in the same cycle -> counter=0, state IDLE, no done; a start pulse in RUN before the abort is ignored and counter is unchanged.
REQ-031 RELOAD=1, value=2, en=1 continuous -> counter 2,1,0,2,1,0...; done every 3rd cycle; abort returns to IDLE with counter=0.
